// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/grant/response channel,
// decode-side instruction handshake and the EX redirect inputs.
// master = fetch unit side, slave = memory / pipeline side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Ins;
  logic [31:0] nextPC;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect;
  logic [31:0] newPC;

  modport master (
    output imem_req, imem_addr, Ins, nextPC, ins_valid,
    input  imem_gnt, imem_rvalid, imem_rdata, ins_ready, redirect, newPC
  );

  modport slave (
    input  imem_req, imem_addr, Ins, nextPC, ins_valid,
    output imem_gnt, imem_rvalid, imem_rdata, ins_ready, redirect, newPC
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch front end: owns the PC, issues one word fetch at a
// time to instruction memory and buffers returned words with their PC+4.
// A redirect from EX reloads the PC and flushes all wrong-path work.
// Optional macro FETCH_BYPASS_EN: a response arriving into an empty buffer is
// presented on Ins/nextPC/ins_valid in the same cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic         CLK,
  input logic         RST,
  fetch_unit_if.master bus
);

  localparam int unsigned    PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc;
  logic [31:0]        req_pc;
  logic               drop;
  logic [PTR_W:0]     count;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [31:0]        ins_mem [DEPTH];
  logic [31:0]        pc_mem  [DEPTH];

  logic               req;
  logic               fire;
  logic               resp_ok;
  logic               bypass;
  logic               head_valid;
  logic               push;
  logic               pop;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and request generation; requests are withheld during a
  // redirect so a grant can never race the PC reload.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        req = !RST && (count < FULL) && !bus.redirect;
        if (req && bus.imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fire       = req && bus.imem_gnt;
  assign resp_ok    = (state_q == WAIT) && bus.imem_rvalid && !drop && !bus.redirect;
  assign head_valid = (count != '0);
`ifdef FETCH_BYPASS_EN
  assign bypass     = resp_ok && !head_valid;
`else
  assign bypass     = 1'b0;
`endif
  // A bypassed word that is consumed immediately never enters the buffer.
  assign push       = resp_ok && !(bypass && bus.ins_ready);
  assign pop        = head_valid && bus.ins_ready && !bus.redirect;

  // Output mux: buffer head first, otherwise the bypassed response, else NOP.
  always_comb begin
    bus.ins_valid = head_valid || bypass;
    bus.Ins       = '0;
    bus.nextPC    = '0;
    if (head_valid) begin
      bus.Ins    = ins_mem[rd_ptr];
      bus.nextPC = pc_mem[rd_ptr];
    end else if (bypass) begin
      bus.Ins    = bus.imem_rdata;
      bus.nextPC = req_pc + 32'd4;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;

  // PC, drop flag and buffer bookkeeping; redirect overrides push/pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      drop     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (fire) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (state_q == WAIT && bus.imem_rvalid) drop <= 1'b0;
      if (bus.redirect) begin
        fetch_pc <= bus.newPC & ~32'd3;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        if (state_q == WAIT && !bus.imem_rvalid) drop <= 1'b1;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Buffer storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push) begin
      ins_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]  <= req_pc + 32'd4;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the MIPS pipeline: owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers fetched words.
- Delivers each instruction with its PC+4 (Ins, nextPC) to decode/EX.
- Consumes the EX-computed target (newPC) on a redirect, flushing everything fetched down the wrong path.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, instruction buffer entries; power of two, 2..8.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address; bits [1:0] always 00.
- imem_gnt  in  1  memory accepts the request this cycle; meaningful only when imem_req=1.
- imem_rvalid  in  1  fetched word valid; responses return in order, at least 1 cycle after grant.
- imem_rdata  in  32  fetched instruction word.
- Ins  out  32  instruction at buffer head; 0 (NOP) when ins_valid=0.
- nextPC  out  32  fetch address of Ins + 4; 0 when ins_valid=0.
- ins_valid  out  1  buffer head is valid.
- ins_ready  in  1  downstream consumes the head when ins_valid=1.
- redirect  in  1  EX takes a branch or jump this cycle.
- newPC  in  32  redirect target; bits [1:0] ignored and forced to 00.

Behaviour:
- Reset: fetch_pc=RESET_PC, buffer empty (count=0), FSM=IDLE, drop=0. All outputs read 0: imem_req, ins_valid, Ins, nextPC; imem_addr=RESET_PC. RST mid-transfer abandons any outstanding request. Any response arriving after reset is ignored while FSM=IDLE.
- FSM IDLE, no request outstanding:
  - imem_req=1 iff count<DEPTH and redirect=0.
  - imem_addr=fetch_pc.
  - On req&gnt: latch req_pc=fetch_pc, set fetch_pc+=4 (wraps modulo 2^32), go to WAIT.
- FSM WAIT, one request outstanding:
  - imem_req=0.
  - On imem_rvalid, go to IDLE.
  - If drop=0: push {imem_rdata, req_pc+4}.
  - If drop=1: discard the word and clear drop.
- At most one request is ever outstanding. With count<DEPTH checked at issue, a push never overflows.
- Pop on ins_valid&ins_ready. Push and pop in the same cycle is legal at any count, including full; count is unchanged.
- Redirect (highest priority):
  - fetch_pc={newPC[31:2],2'b00}.
  - Buffer flushed: count=0, and any pop that cycle is ignored.
  - If FSM=WAIT and rvalid=0, set drop=1.
  - If rvalid arrives in the redirect cycle, that word is discarded and FSM goes to IDLE.
  - Because imem_req is suppressed during a redirect cycle, there is no grant/redirect race.
  - Redirect while drop=1 keeps drop=1 and updates fetch_pc again.
- Latency without bypass: rvalid at cycle N makes ins_valid=1 at cycle N+1. Back-to-back fetch throughput is one word per 2 cycles when memory has 1-cycle latency.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When count=0, FSM=WAIT, drop=0, imem_rvalid=1 and redirect=0, Ins/nextPC/ins_valid are driven combinationally from imem_rdata/req_pc+4 in the same cycle.
  - If ins_ready=1, the word is consumed and not written to the buffer; otherwise it is pushed normally.
  - Response-to-output latency becomes 0 cycles.
- Undefined: all responses pass through the buffer; latency is 1 cycle; no combinational path from imem_* to Ins/nextPC/ins_valid.

Test Plan:
- Reset, then release; memory grants every request, 1-cycle response of 32'h2000_0000+addr; ins_ready=1 -> imem_addr sequence 0,4,8,... Ins=32'h2000_0000,32'h2000_0004,... with nextPC=4,8,12.
- ins_ready=0 with DEPTH=2 -> exactly 2 fetches (addr 0,4), then imem_req stays 0. Raise ins_ready -> heads pop in order, fetching resumes at addr 8.
- redirect=1, newPC=32'h0000_0103 while FSM=WAIT for addr 8 -> the addr-8 response is discarded, buffer empties, next imem_addr=32'h0000_0100, first delivered nextPC=32'h0000_0104.
- redirect in the same cycle as imem_rvalid -> that word never appears on Ins. imem_req=0 in the redirect cycle.
- Full buffer with pop and push in the same cycle -> count stays DEPTH, FIFO order preserved. RST asserted during WAIT -> next cycle all outputs 0, imem_addr=RESET_PC.
- With FETCH_BYPASS_EN, empty buffer, rvalid with rdata=32'h0123_4567, ins_ready=1 -> ins_valid=1 and Ins=32'h0123_4567 in the same cycle. Without the macro, this appears one cycle later.
